// File: rtl/dma_tlp_tx_pkg.sv
// Shared constants, types and header helpers for the DMA upstream TLP engine.
package dma_tlp_tx_pkg;

    localparam int         DMA_TLP_SIZE   = 32;
    localparam logic [6:0] MWR32_FMT_TYPE = 7'b10_00000;
    localparam logic [7:0] TREM_FULL      = 8'h00;
    localparam logic [7:0] TREM_UPPER     = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TAIL
    } tx_state_t;

    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
    } mwr_dw1_t;

    // DW0 of a 3DW MWr32: TC, TD, EP and attributes are always zero here.
    function automatic logic [31:0] mwr32_dw0(input logic [9:0] len_dw);
        return {1'b0, MWR32_FMT_TYPE, 1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 2'b00, 2'b00, len_dw};
    endfunction

endpackage

// File: rtl/dma_tlp_tx.sv
// Emits one MWr32 TLP (3DW header + TLP_DW payload) from an FWFT FIFO on the 64-bit TRN TX bus.
// Latency: header one cycle after dma_start; each beat advances only when trn_tdst_rdy_n is low.
// Backpressure: stalls hold td/framing; endpoint discontinue aborts to IDLE and sets dsc_err.
module dma_tlp_tx
    import dma_tlp_tx_pkg::*;
#(
    parameter int TLP_DW = DMA_TLP_SIZE,
    parameter int CNT_W  = 12
) (
    input  logic             trn_clk,
    input  logic             trn_reset_n,

    input  logic             dma_start,
    input  logic [29:0]      dma_addr,
    output logic             dma_ready,
    output logic             dma_rd_en,

    input  logic [15:0]      cfg_completer_id,
    input  logic             cfg_bus_mstr_enable,

    input  logic [63:0]      fifo_dout,
    input  logic [CNT_W-1:0] fifo_rd_count,
    output logic             fifo_rd,

    output logic [63:0]      trn_td,
    output logic [7:0]       trn_trem_n,
    output logic             trn_tsof_n,
    output logic             trn_teof_n,
    output logic             trn_tsrc_rdy_n,
    output logic             trn_tsrc_dsc_n,
    input  logic             trn_tdst_rdy_n,
    input  logic             trn_tdst_dsc_n,
    input  logic [3:0]       trn_tbuf_av,

    output logic             dsc_err
);

    localparam int              BEATS     = TLP_DW / 2;
    localparam int              BC_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    tx_state_t       state;
    logic [29:0]     addr_q;
    logic [31:0]     hold_q;
    logic [BC_W-1:0] beat_cnt;
    logic            accept;
    logic            abort;
    logic            can_start;
    mwr_dw1_t        hdr_dw1;

    // Only the posted-header credit bit matters for a memory write.
    logic unused_tbuf;
    assign unused_tbuf = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};

    assign accept    = ~trn_tdst_rdy_n;
    assign abort     = ~trn_tdst_dsc_n & (state != ST_IDLE);
    assign can_start = (fifo_rd_count >= CNT_W'(BEATS)) & trn_tbuf_av[1] & cfg_bus_mstr_enable;

    assign trn_tsrc_dsc_n = 1'b1;

    // A discontinue in the same cycle as an accept wins, so no word is popped then.
    assign fifo_rd = (state == ST_DATA) & accept & trn_tdst_dsc_n;

    always_comb begin
        hdr_dw1          = '0;
        hdr_dw1.req_id   = cfg_completer_id;
        hdr_dw1.tag      = 8'h00;
        hdr_dw1.last_be  = 4'hF;
        hdr_dw1.first_be = 4'hF;
    end

    // The payload is shifted by one DW behind the header's address DW, so each
    // beat pairs the previous word's lower DW with the FIFO head's upper DW.
    always_comb begin
        trn_td = '0;
        case (state)
            ST_HDR:  trn_td = {mwr32_dw0(10'(TLP_DW)), hdr_dw1};
            ST_DATA: trn_td = {(beat_cnt == '0) ? {addr_q, 2'b00} : hold_q, fifo_dout[63:32]};
            ST_TAIL: trn_td = {hold_q, 32'h0};
            default: trn_td = '0;
        endcase
    end

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            hold_q         <= '0;
            beat_cnt       <= '0;
            dma_ready      <= 1'b0;
            dma_rd_en      <= 1'b0;
            trn_tsrc_rdy_n <= 1'b1;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_trem_n     <= TREM_FULL;
            dsc_err        <= 1'b0;
        end else begin
            dma_ready <= (state == ST_IDLE) & can_start;
            if (abort) begin
                state          <= ST_IDLE;
                beat_cnt       <= '0;
                dma_rd_en      <= 1'b0;
                trn_tsrc_rdy_n <= 1'b1;
                trn_tsof_n     <= 1'b1;
                trn_teof_n     <= 1'b1;
                trn_trem_n     <= TREM_FULL;
                dsc_err        <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (dma_start) begin
                            addr_q         <= dma_addr;
                            state          <= ST_HDR;
                            trn_tsrc_rdy_n <= 1'b0;
                            trn_tsof_n     <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        if (accept) begin
                            state      <= ST_DATA;
                            beat_cnt   <= '0;
                            trn_tsof_n <= 1'b1;
                            dma_rd_en  <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            hold_q <= fifo_dout[31:0];
                            if (beat_cnt == LAST_BEAT) begin
                                beat_cnt   <= '0;
                                state      <= ST_TAIL;
                                trn_teof_n <= 1'b0;
                                trn_trem_n <= TREM_UPPER;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    ST_TAIL: begin
                        if (accept) begin
                            state          <= ST_IDLE;
                            dma_rd_en      <= 1'b0;
                            trn_tsrc_rdy_n <= 1'b1;
                            trn_teof_n     <= 1'b1;
                            trn_trem_n     <= TREM_FULL;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
